// File: rtl/eth_frame_rx.sv
// rtl/eth_frame_rx.sv - GMII-style byte-serial Ethernet frame receiver with valid/ready delivery
//
// Parses preamble, SFD, destination MAC, source MAC, EtherType and a 32-bit
// payload. Frames addressed to MAC_ADDR_LOCAL carrying ETH_TYPE_IPV4 are
// delivered through a single-entry output register. Every burst is counted
// as either delivered (rx_ok_cnt) or dropped (rx_drop_cnt).
//
// Optional feature: define ETH_RX_BCAST_EN to also accept the broadcast
// destination 48'hFFFFFFFFFFFF.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_dv, rxd, rx_er  receive strobe, byte and PHY error
//   tcp_ip_rx_data     delivered payload, first byte in [31:24]
//   tcp_ip_rx_valid    output register full
//   tcp_ip_rx_ready    consumer accepts the output register
//   rx_src_mac         source MAC of the delivered frame
//   rx_ok_cnt          delivered frames, saturating
//   rx_drop_cnt        dropped bursts, saturating
module eth_frame_rx #(
  parameter logic [47:0] MAC_ADDR_LOCAL = 48'h000A35000001,
  parameter logic [15:0] ETH_TYPE_IPV4  = 16'h0800,
  parameter int          MIN_PREAMBLE   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  input  logic        rx_er,
  output logic [31:0] tcp_ip_rx_data,
  output logic        tcp_ip_rx_valid,
  input  logic        tcp_ip_rx_ready,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_ok_cnt,
  output logic [15:0] rx_drop_cnt
);

  typedef enum logic [2:0] {
    S_SYNC, S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TAIL, S_DROP
  } state_t;

  state_t      state;
  logic [2:0]  pre_cnt;
  logic [3:0]  idx;
  logic [47:0] dst_sr;
  logic [47:0] src_sr;
  logic [15:0] type_sr;
  logic [31:0] pay_sr;

  logic dst_ok;
  logic frame_ok;
  logic slot_free;

  always_comb begin
    dst_ok = (dst_sr == MAC_ADDR_LOCAL);
`ifdef ETH_RX_BCAST_EN
    dst_ok = dst_ok || (dst_sr == 48'hFFFF_FFFF_FFFF);
`else
`endif
    // Only a frame that reached TAIL has a complete header and payload.
    frame_ok  = (state == S_TAIL) && dst_ok && (type_sr == ETH_TYPE_IPV4);
    // The slot is free if empty or being drained on this very edge.
    slot_free = !tcp_ip_rx_valid || tcp_ip_rx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_SYNC;
      pre_cnt         <= 3'd0;
      idx             <= 4'd0;
      dst_sr          <= 48'd0;
      src_sr          <= 48'd0;
      type_sr         <= 16'd0;
      pay_sr          <= 32'd0;
      tcp_ip_rx_data  <= 32'd0;
      tcp_ip_rx_valid <= 1'b0;
      rx_src_mac      <= 48'd0;
      rx_ok_cnt       <= 16'd0;
      rx_drop_cnt     <= 16'd0;
    end else begin
      // Drain first; a load later in this block overrides the clear.
      if (tcp_ip_rx_valid && tcp_ip_rx_ready)
        tcp_ip_rx_valid <= 1'b0;

      case (state)
        S_SYNC: begin
          if (!rx_dv)
            state <= S_IDLE;
        end
        S_IDLE: begin
          if (rx_dv) begin
            if (rxd == 8'h55) begin
              state   <= S_PREAMBLE;
              pre_cnt <= 3'd1;
            end else begin
              state <= S_DROP;
            end
          end
        end
        default: begin
          if (!rx_dv) begin
            // End of burst: every burst is counted exactly once here.
            state <= S_IDLE;
            if (frame_ok && slot_free) begin
              tcp_ip_rx_data  <= pay_sr;
              rx_src_mac      <= src_sr;
              tcp_ip_rx_valid <= 1'b1;
              if (rx_ok_cnt != 16'hFFFF)
                rx_ok_cnt <= rx_ok_cnt + 16'd1;
            end else begin
              if (rx_drop_cnt != 16'hFFFF)
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end
          end else if (rx_er && state != S_DROP) begin
            state <= S_DROP;
          end else begin
            case (state)
              S_PREAMBLE: begin
                if (rxd == 8'h55) begin
                  if (pre_cnt != 3'd7)
                    pre_cnt <= pre_cnt + 3'd1;
                end else if (rxd == 8'hD5 && pre_cnt >= 3'(MIN_PREAMBLE)) begin
                  state <= S_HEADER;
                  idx   <= 4'd0;
                end else begin
                  state <= S_DROP;
                end
              end
              S_HEADER: begin
                if (idx < 4'd6)
                  dst_sr <= {dst_sr[39:0], rxd};
                else if (idx < 4'd12)
                  src_sr <= {src_sr[39:0], rxd};
                else
                  type_sr <= {type_sr[7:0], rxd};
                if (idx == 4'd13) begin
                  state <= S_PAYLOAD;
                  idx   <= 4'd0;
                end else begin
                  idx <= idx + 4'd1;
                end
              end
              S_PAYLOAD: begin
                pay_sr <= {pay_sr[23:0], rxd};
                idx    <= idx + 4'd1;
                if (idx == 4'd3)
                  state <= S_TAIL;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_rx.sv
// tb/tb_eth_frame_rx.sv - scoreboard testbench for eth_frame_rx
module tb_eth_frame_rx;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [31:0] data; logic [47:0] src; } exp_t;

  localparam logic [47:0] LOCAL = 48'h000A35000001;
  localparam int          MIN_PRE = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rxd;
  logic        rx_er;
  logic [31:0] tcp_ip_rx_data;
  logic        tcp_ip_rx_valid;
  logic        tcp_ip_rx_ready;
  logic [47:0] rx_src_mac;
  logic [15:0] rx_ok_cnt;
  logic [15:0] rx_drop_cnt;

  eth_frame_rx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_dv           (rx_dv),
    .rxd             (rxd),
    .rx_er           (rx_er),
    .tcp_ip_rx_data  (tcp_ip_rx_data),
    .tcp_ip_rx_valid (tcp_ip_rx_valid),
    .tcp_ip_rx_ready (tcp_ip_rx_ready),
    .rx_src_mac      (rx_src_mac),
    .rx_ok_cnt       (rx_ok_cnt),
    .rx_drop_cnt     (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic m_valid = 1'b0;
  int   m_ok = 0;
  int   m_drop = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake visible at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && tcp_ip_rx_valid && tcp_ip_rx_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", {32'd0, tcp_ip_rx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("deliver_data", {32'd0, tcp_ip_rx_data}, {32'd0, e.data});
        chk("deliver_src", {16'd0, rx_src_mac}, {16'd0, e.src});
      end
    end
  end

  function automatic logic pick_ready(input logic is_end);
    case (ready_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return is_end;
    endcase
  endfunction

  // Reference: decide a burst's fate directly from its byte list.
  function automatic logic model_accept(input bq_t b, input int er_pos,
                                        output logic [31:0] d, output logic [47:0] s);
    int n;
    int p;
    logic [47:0] dst;
    logic [15:0] ty;
    logic bc;
    n = b.size();
    p = 0;
    d = 0; s = 0; dst = 0;
    if (n == 0 || b[0] != 8'h55) return 1'b0;
    while (p < n && b[p] == 8'h55) p++;
    if (p + 19 > n) return 1'b0;
    if (b[p] != 8'hD5 || p < MIN_PRE) return 1'b0;
    if (er_pos >= 1) return 1'b0;
    for (int k = 0; k < 6; k++) begin
      dst = {dst[39:0], b[p + 1 + k]};
      s   = {s[39:0], b[p + 7 + k]};
    end
    ty = {b[p + 13], b[p + 14]};
    for (int k = 0; k < 4; k++) d = {d[23:0], b[p + 15 + k]};
`ifdef ETH_RX_BCAST_EN
    bc = 1'b1;
`else
    bc = 1'b0;
`endif
    return ((dst == LOCAL) || (bc && dst == 48'hFFFF_FFFF_FFFF)) && ty == 16'h0800;
  endfunction

  function automatic bq_t make_frame(input int pre, input logic [47:0] dst, input logic [47:0] src,
                                     input logic [15:0] ty, input logic [31:0] pl, input int pad);
    bq_t q;
    logic [111:0] hdr;
    for (int i = 0; i < pre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    hdr = {dst, src, ty};
    for (int i = 13; i >= 0; i--) q.push_back(hdr[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(pl[i*8 +: 8]);
    for (int i = 0; i < pad; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic idle_cycle(input logic r);
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    tcp_ip_rx_ready = r;
    @(posedge clk);
    if (m_valid && tcp_ip_rx_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic burst(input bq_t b, input int er_pos, input int gap);
    logic [31:0] d;
    logic [47:0] s;
    logic acc;
    acc = model_accept(b, er_pos, d, s);
    foreach (b[i]) begin
      rx_dv = 1'b1; rxd = b[i]; rx_er = (i == er_pos);
      tcp_ip_rx_ready = pick_ready(1'b0);
      @(posedge clk);
      if (m_valid && tcp_ip_rx_ready) m_valid = 1'b0;
      #1;
    end
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    tcp_ip_rx_ready = pick_ready(1'b1);
    @(posedge clk);
    if (acc && (!m_valid || tcp_ip_rx_ready)) begin
      exp_q.push_back('{data: d, src: s});
      m_valid = 1'b1;
      if (m_ok < 65535) m_ok++;
    end else begin
      if (m_valid && tcp_ip_rx_ready) m_valid = 1'b0;
      if (m_drop < 65535) m_drop++;
    end
    #1;
    chk("end_valid", {63'd0, tcp_ip_rx_valid}, {63'd0, m_valid});
    chk("ok_cnt", {48'd0, rx_ok_cnt}, 64'(m_ok));
    chk("drop_cnt", {48'd0, rx_drop_cnt}, 64'(m_drop));
    for (int g = 0; g < gap; g++) idle_cycle(pick_ready(1'b0));
  endtask

  initial begin
    bq_t f;
    int base;
    rst_n = 1'b0; rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0; tcp_ip_rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {32'd0, tcp_ip_rx_data}, 64'd0);
    chk("rst_src", {16'd0, rx_src_mac}, 64'd0);
    chk("rst_valid", {63'd0, tcp_ip_rx_valid}, 64'd0);
    chk("rst_ok", {48'd0, rx_ok_cnt}, 64'd0);
    chk("rst_drop", {48'd0, rx_drop_cnt}, 64'd0);
    rst_n = 1'b1;
    idle_cycle(1'b0);

    // Good frame
    ready_mode = 1;
    burst(make_frame(7, LOCAL, 48'h000A35000002, 16'h0800, 32'hDEADBEEF, 2), -1, 0);
    chk("good_data", {32'd0, tcp_ip_rx_data}, 64'hDEADBEEF);
    chk("good_src", {16'd0, rx_src_mac}, 64'h000A35000002);
    chk("good_ok", {48'd0, rx_ok_cnt}, 64'd1);
    idle_cycle(1'b1);

    // Filter drops
    base = m_drop;
    burst(make_frame(7, 48'h000A35000003, 48'h1, 16'h0800, 32'h1, 0), -1, 1);
    burst(make_frame(7, LOCAL, 48'h1, 16'h86DD, 32'h2, 0), -1, 1);
    chk("filter_drops", {48'd0, rx_drop_cnt} - 64'(base), 64'd2);

    // Error, runt, short preamble
    base = m_drop;
    burst(make_frame(7, LOCAL, 48'h2, 16'h0800, 32'h3, 1), 8 + 14 + 1, 1);
    f = make_frame(7, LOCAL, 48'h2, 16'h0800, 32'h4, 1);
    f = f[0:17];
    burst(f, -1, 1);
    burst(make_frame(3, LOCAL, 48'h2, 16'h0800, 32'h5, 1), -1, 1);
    chk("err_drops", {48'd0, rx_drop_cnt} - 64'(base), 64'd3);
    chk("err_valid", {63'd0, tcp_ip_rx_valid}, 64'd0);

    // Overflow
    ready_mode = 0;
    base = m_drop;
    burst(make_frame(7, LOCAL, 48'hA, 16'h0800, 32'h11223344, 0), -1, 0);
    burst(make_frame(7, LOCAL, 48'hB, 16'h0800, 32'h55667788, 0), -1, 0);
    chk("ovf_hold", {32'd0, tcp_ip_rx_data}, 64'h11223344);
    chk("ovf_drop", {48'd0, rx_drop_cnt} - 64'(base), 64'd1);
    idle_cycle(1'b1);
    chk("ovf_fall", {63'd0, tcp_ip_rx_valid}, 64'd0);
    burst(make_frame(7, LOCAL, 48'hC, 16'h0800, 32'hCAFE0001, 0), -1, 0);
    ready_mode = 3;
    burst(make_frame(7, LOCAL, 48'hD, 16'h0800, 32'hCAFE0002, 0), -1, 0);
    chk("nogap_data", {32'd0, tcp_ip_rx_data}, 64'hCAFE0002);
    chk("nogap_valid", {63'd0, tcp_ip_rx_valid}, 64'd1);
    idle_cycle(1'b1);

    // Broadcast
    ready_mode = 1;
    burst(make_frame(7, 48'hFFFF_FFFF_FFFF, 48'hE, 16'h0800, 32'h0A0B0C0D, 0), -1, 1);

    // Reset mid-frame
    ready_mode = 0;
    f = make_frame(7, LOCAL, 48'hF, 16'h0800, 32'h77777777, 0);
    for (int i = 0; i < f.size(); i++) begin
      rx_dv = 1'b1; rxd = f[i]; rx_er = 1'b0; tcp_ip_rx_ready = 1'b0;
      @(posedge clk);
      #1;
      if (i == 12) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {32'd0, tcp_ip_rx_data}, 64'd0);
        chk("mid_rst_src", {16'd0, rx_src_mac}, 64'd0);
        chk("mid_rst_valid", {63'd0, tcp_ip_rx_valid}, 64'd0);
        chk("mid_rst_ok", {48'd0, rx_ok_cnt}, 64'd0);
        chk("mid_rst_drop", {48'd0, rx_drop_cnt}, 64'd0);
        m_valid = 1'b0; m_ok = 0; m_drop = 0; exp_q.delete();
        #1 rst_n = 1'b1;
      end
    end
    idle_cycle(1'b0);
    chk("post_rst_ok", {48'd0, rx_ok_cnt}, 64'd0);
    chk("post_rst_drop", {48'd0, rx_drop_cnt}, 64'd0);
    ready_mode = 1;
    burst(make_frame(7, LOCAL, 48'h000A35000002, 16'h0800, 32'h12345678, 0), -1, 1);
    chk("post_rst_good", {48'd0, rx_ok_cnt}, 64'd1);

    // Randomized frames
    ready_mode = 2;
    for (int t = 0; t < 200; t++) begin
      logic [47:0] dst;
      logic [15:0] ty;
      int er;
      case ($urandom_range(0, 3))
        0: dst = 48'h000A35000003;
        1: dst = 48'hFFFF_FFFF_FFFF;
        default: dst = LOCAL;
      endcase
      ty = ($urandom_range(0, 4) == 0) ? 16'h86DD : 16'h0800;
      f = make_frame($urandom_range(5, 9), dst, {16'($urandom), 32'($urandom)}, ty,
                     32'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        int len;
        len = $urandom_range(1, f.size());
        while (f.size() > len) void'(f.pop_back());
      end
      if ($urandom_range(0, 19) == 0) f[0] = 8'($urandom);
      er = ($urandom_range(0, 9) == 0) ? $urandom_range(0, f.size() - 1) : -1;
      burst(f, er, $urandom_range(0, 2));
    end

    repeat (4) idle_cycle(1'b1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_rx.md
# eth_frame_rx

Byte-serial Ethernet frame receiver on the PHY side of the TCP/IP stack. It parses a GMII-style receive stream: preamble, SFD, destination MAC, source MAC, EtherType and a 32-bit payload. Matching frames are delivered to the TCP/IP receive interface through a single-entry valid/ready output register. Every frame burst is counted as either accepted or dropped.

## Interface
- `MAC_ADDR_LOCAL`, 48'h000A35000001, destination address accepted.
- `ETH_TYPE_IPV4`, 16'h0800, EtherType accepted.
- `MIN_PREAMBLE`, 7, minimum number of 0x55 bytes required before the SFD (range 1..7).
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_dv` in 1: frame burst strobe; one byte per cycle while high.
- `rxd` in 8: receive byte.
- `rx_er` in 1: PHY error, sampled only while `rx_dv`=1.
- `tcp_ip_rx_data` out 32: delivered payload, first byte in bits [31:24].
- `tcp_ip_rx_valid` out 1: output register full.
- `tcp_ip_rx_ready` in 1: consumer accepts.
- `rx_src_mac` out 48: source MAC of the delivered frame; updates together with `tcp_ip_rx_data`.
- `rx_ok_cnt` out 16: count of delivered frames, saturating.
- `rx_drop_cnt` out 16: count of dropped bursts, saturating.

## Operation
- States: SYNC, IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL, DROP.
- SYNC:
  - Reset state.
  - Ignores data; moves to IDLE when `rx_dv`=0.
  - Nothing is counted in SYNC.
- IDLE, when `rx_dv`=1:
  - `rxd`=0x55: go to PREAMBLE with the preamble count set to 1.
  - Any other byte: go to DROP.
- PREAMBLE:
  - 0x55: increment the 3-bit count, saturating at 7.
  - 0xD5 with count ≥ `MIN_PREAMBLE`: go to HEADER with the byte index set to 0.
  - Any other byte, or SFD with a short preamble: go to DROP.
- HEADER: 14 bytes, MSB first.
  - Bytes 0-5: destination MAC.
  - Bytes 6-11: source MAC.
  - Bytes 12-13: EtherType.
  - After byte 13, go to PAYLOAD.
- PAYLOAD:
  - 4 bytes shift into the payload register.
  - After byte 3, go to TAIL.
- TAIL: ignores pad and FCS bytes.
- DROP: ignores bytes until `rx_dv`=0.
- `rx_er`=1 with `rx_dv`=1 in PREAMBLE, HEADER, PAYLOAD or TAIL: go to DROP.
- End of burst is the first edge sampling `rx_dv`=0 outside SYNC/IDLE.
  - The frame is accepted only if all of the following hold: state is TAIL, destination = `MAC_ADDR_LOCAL`, and EtherType = `ETH_TYPE_IPV4`.
  - If accepted and the slot is free (`tcp_ip_rx_valid`=0, or `tcp_ip_rx_valid`=1 and `tcp_ip_rx_ready`=1 this cycle), load data and `rx_src_mac`, set valid, increment `rx_ok_cnt`.
  - If accepted but the slot is occupied: drop. The held data is unchanged; increment `rx_drop_cnt`.
  - Any other end of burst increments `rx_drop_cnt`.
  - All of these cases return to IDLE.
- Invariant: `rx_ok_cnt` + `rx_drop_cnt` equals the number of `rx_dv` bursts that started outside SYNC, until either counter saturates.
- Output register:
  - `tcp_ip_rx_valid` clears on `tcp_ip_rx_ready`=1, unless a new frame is loaded that same cycle.
  - Data is held stable while valid and not ready.
- The receive side has no backpressure. Bytes are never stalled.

## Timing
- Reset values:
  - `tcp_ip_rx_data`=0, `rx_src_mac`=0.
  - `tcp_ip_rx_valid`=0.
  - Both counters =0.
  - State SYNC.
- Reset asserted mid-frame: the burst is abandoned without counting. After release, the block waits in SYNC for `rx_dv`=0.
- Latency:
  - `tcp_ip_rx_valid` rises at the same edge that first samples `rx_dv`=0 after an accepted frame.
  - Counters update at that same edge.
- Minimum inter-frame gap is one cycle of `rx_dv`=0. A burst may start on the edge right after the end edge.
- Counters stick at 16'hFFFF.

## Configuration
- `ETH_RX_BCAST_EN` defined: destination 48'hFFFFFFFFFFFF is also accepted.
- `ETH_RX_BCAST_EN` undefined: only `MAC_ADDR_LOCAL` is accepted; broadcast frames are dropped and counted.

## Test plan
- Good frame:
  - Stimulus: 7×0x55, D5, dst 000A35000001, src 000A35000002, type 0800, payload DE AD BE EF, 2 pad bytes, then `rx_dv` low.
  - Required response: `tcp_ip_rx_data`=32'hDEADBEEF, `rx_src_mac`=48'h000A35000002, valid at the edge sampling `rx_dv` low, `rx_ok_cnt`=1.
- Filter drops:
  - Stimulus: dst 000A35000003 in one frame, type 86DD in another.
  - Required response: no valid, `rx_drop_cnt`=2.
- Error and runt:
  - Stimulus: one frame with `rx_er` pulsed on payload byte 1; one frame with `rx_dv` falling after 10 header bytes; one frame with a 3-byte preamble.
  - Required response: `rx_drop_cnt`=3, valid stays 0.
- Overflow:
  - Stimulus: with ready held 0, payload 11223344 then payload 55667788; then ready=1 for one cycle.
  - Required response: data stays 11223344, `rx_drop_cnt`=1; valid falls after the ready cycle.
  - Stimulus: a third frame ending on a cycle where ready=1.
  - Required response: it loads without a gap.
- Broadcast:
  - Stimulus: dst FFFFFFFFFFFF, payload 0A0B0C0D.
  - Required response: delivered with `ETH_RX_BCAST_EN` defined; dropped (`rx_drop_cnt`=1) without it.
- Reset mid-frame:
  - Stimulus: `rst_n` pulsed during HEADER while `rx_dv` stays high.
  - Required response: all outputs 0, remainder of the burst not counted. The next good frame delivers with `rx_ok_cnt`=1.
